// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line levels and the TX state encoding.
// The RX path imports the same constants so both sides agree on the frame format.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 11;

    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with a registered occupancy count and registered full flag.
// A push while full is dropped even if a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     l_ready_reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         dout
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push && !full_q;
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk or posedge l_ready_reset) begin
        if (l_ready_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign full  = full_q;
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO front end feeding an 8E1 serialiser.
// Frames go out back to back while the FIFO has data; the line idles high.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          l_ready_reset,
    input  logic [UART_DATA_BITS-1:0]     data,
    input  logic                          write,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          tx_o
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    uart_state_e               state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      parity_q, parity_d;
    logic                      tx_q, tx_d;
    logic                      line_active_q, line_active_d;

    logic                      fifo_pop;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk           (clk),
        .l_ready_reset (l_ready_reset),
        .push          (write),
        .din           (data),
        .pop           (fifo_pop),
        .full          (full),
        .empty         (fifo_empty),
        .count         (count),
        .dout          (fifo_dout)
    );

    assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d       = state_q;
        baud_d        = bit_end ? '0 : baud_q + BAUD_W'(1);
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        fifo_pop      = 1'b0;
        tx_d          = UART_STOP_LVL;
        line_active_d = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    parity_d = uart_even_parity(fifo_dout);
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                tx_d = UART_START_LVL;
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                tx_d = parity_q;
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                tx_d = UART_STOP_LVL;
                if (bit_end) begin
                    // Chain straight into the next frame to avoid an idle cycle.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        parity_d = uart_even_parity(fifo_dout);
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The pin is registered, so it trails the state by one cycle; busy spans the pin activity.
    always_ff @(posedge clk or posedge l_ready_reset) begin
        if (l_ready_reset) begin
            state_q       <= ST_IDLE;
            baud_q        <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            tx_q          <= UART_STOP_LVL;
            line_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            tx_q          <= tx_d;
            line_active_q <= line_active_d;
        end
    end

    assign tx_o     = tx_q;
    assign overflow = write && full;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty || line_active_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed and random writes compared each
// cycle against a frame-timeline model of the FIFO and the serial line.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 11 * CPB;

    logic       clk = 1'b0;
    logic       l_ready_reset;
    logic [7:0] data;
    logic       write;
    logic       full;
    logic       overflow;
    logic [3:0] count;
    logic       busy;
    logic       tx_o;

    int vectors    = 0;
    int miscompares = 0;
    int e          = 0;

    // Model: one entry per accepted byte: write edge, first tx-low edge, byte value.
    int         fw[$];
    int         fs[$];
    logic [7:0] fb[$];

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .l_ready_reset (l_ready_reset),
        .data          (data),
        .write         (write),
        .full          (full),
        .overflow      (overflow),
        .count         (count),
        .busy          (busy),
        .tx_o          (tx_o)
    );

    always #5 clk = ~clk;

    function automatic int mcount(input int t);
        int n = 0;
        foreach (fw[i]) begin
            if (fw[i] <= t) n++;
            if (fs[i] - 1 <= t) n--;
        end
        return n;
    endfunction

    function automatic logic mline(input int t);
        logic [10:0] fr;
        foreach (fs[i]) begin
            if (t >= fs[i] && t < fs[i] + FRAME) begin
                fr = {1'b1, ^fb[i], fb[i], 1'b0};
                return fr[(t - fs[i]) / CPB];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic mbusy(input int t);
        foreach (fs[i]) begin
            if (fw[i] <= t && t < fs[i] + FRAME) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    // Entered #1 after edge e; checks outputs after edge e, then advances one edge.
    task automatic step(input logic wr, input logic [7:0] d);
        int   n;
        logic full_exp;
        int   s;
        write = wr;
        data  = d;
        #1;
        n        = mcount(e);
        full_exp = (n == DEPTH);
        chk("tx_o",     32'(tx_o),     32'(mline(e)));
        chk("count",    32'(count),    32'(n));
        chk("full",     32'(full),     32'(full_exp));
        chk("busy",     32'(busy),     32'(mbusy(e)));
        chk("overflow", 32'(overflow), 32'(wr && full_exp));
        if (wr && !full_exp) begin
            s = e + 3;
            if (fs.size() > 0 && fs[$] + FRAME > s) s = fs[$] + FRAME;
            fw.push_back(e + 1);
            fs.push_back(s);
            fb.push_back(d);
        end
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00);
    endtask

    task automatic drain();
        int n = 5;
        if (fs.size() > 0 && fs[$] + FRAME - e + 5 > n) n = fs[$] + FRAME - e + 5;
        idle(n);
    endtask

    task automatic do_reset();
        write = 1'b0;
        l_ready_reset = 1'b1;
        #1;
        chk("rst_tx_o",  32'(tx_o),     32'(1));
        chk("rst_count", 32'(count),    32'(0));
        chk("rst_full",  32'(full),     32'(0));
        chk("rst_busy",  32'(busy),     32'(0));
        chk("rst_ovf",   32'(overflow), 32'(0));
        fw.delete();
        fs.delete();
        fb.delete();
        repeat (2) @(posedge clk);
        #1;
        e += 2;
        l_ready_reset = 1'b0;
    endtask

    initial begin
        l_ready_reset = 1'b1;
        write = 1'b0;
        data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Idle after reset.
        idle(50);

        // Single byte 0xA5 from idle.
        step(1'b1, 8'hA5);
        idle(60);

        // Three back-to-back bytes with parities 0, 0, 1.
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h01);
        drain();

        // Ten consecutive writes: nine accepted, tenth overflows.
        for (int k = 0; k < 10; k++) step(1'b1, 8'($urandom));
        drain();

        // Reset in the middle of DATA of the second queued frame (all-zero byte keeps tx low).
        step(1'b1, 8'($urandom));
        step(1'b1, 8'h00);
        for (int k = 0; k < 200 && e < fs[1] + CPB + 6; k++) step(1'b0, 8'h00);
        chk("mid_frame_tx_low", 32'(tx_o), 32'(mline(e)));
        do_reset();
        idle(100);

        // Continuous writes: full FIFO meets a pop, the write is rejected and count drops.
        for (int k = 0; k < 60; k++) step(1'b1, 8'($urandom));
        drain();

        // Sparse random traffic.
        for (int k = 0; k < 300; k++) step($urandom_range(0, 5) == 0, 8'($urandom));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
